// File: rtl/if_fetch_pkg.sv
//------------------------------------------------------------------------------
// Module  : if_fetch_pkg
// Brief   : Shared types, constants and state encodings for the fetch stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package if_fetch_pkg;

    typedef logic [63:0] InstAddrBus;
    typedef logic [31:0] InstBus;

    localparam logic       RstEnable            = 1'b1;
    localparam InstAddrBus ZeroWord             = 64'h0;
    localparam InstBus     InstZeroWord         = 32'h0;
    localparam InstAddrBus DEFAULT_RESET_VECTOR = 64'h0;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    // Redirect targets are always word aligned before they reach the pc.
    function automatic InstAddrBus align_pc(input InstAddrBus target);
        return {target[63:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_inst_hold_buf.sv
//------------------------------------------------------------------------------
// Module  : if_fetch_inst_hold_buf
// Brief   : Registered pc/instruction pair with load and invalidate.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch_inst_hold_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_invalidate,
    input  logic [63:0] i_pc,
    input  logic [31:0] i_inst,
    output logic        o_valid,
    output logic [63:0] o_pc,
    output logic [31:0] o_inst
);

    logic        r_valid;
    logic [63:0] r_pc;
    logic [31:0] r_inst;

    always_ff @(posedge clk) begin
        if (rst == RstEnable || i_invalidate) begin
            r_valid <= 1'b0;
            r_pc    <= ZeroWord;
            r_inst  <= InstZeroWord;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
//------------------------------------------------------------------------------
// Module  : if_fetch
// Brief   : Instruction fetch stage: pc register, request FSM and stall buffer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch
    import if_fetch_pkg::*;
#(
    parameter InstAddrBus RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [63:0] new_pc,
    input  logic        branch_flag,
    input  logic [63:0] branch_target,
    output logic        rom_ce,
    output logic [63:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        fetch_stall_req
);

    fetch_state_e r_state;
    fetch_state_e w_state_d;
    logic [63:0]  r_pc;
    logic [63:0]  w_pc_d;

    logic         w_buf_load;
    logic         w_buf_inv;
    logic         w_buf_valid;
    logic [63:0]  w_buf_pc;
    logic [31:0]  w_buf_inst;

    logic         w_present;
    logic [63:0]  w_pres_pc;
    logic [31:0]  w_pres_inst;
    logic         w_rom_ce;
    logic         w_fsr;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state <= S_RST;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_pc_d      = r_pc;
        w_buf_load  = 1'b0;
        w_buf_inv   = 1'b0;
        w_present   = 1'b0;
        w_pres_pc   = ZeroWord;
        w_pres_inst = InstZeroWord;
        w_rom_ce    = 1'b0;
        w_fsr       = 1'b0;

        case (r_state)
            S_RST: begin
                w_state_d = S_REQ;
                w_pc_d    = RESET_VECTOR;
            end
            S_REQ: begin
                w_rom_ce = 1'b1;
                w_fsr    = ~rom_ready;
                if (rom_ready) begin
                    w_present   = 1'b1;
                    w_pres_pc   = r_pc;
                    w_pres_inst = rom_data;
                    if (stall) begin
                        w_buf_load = 1'b1;
                        w_state_d  = S_HOLD;
                    end else begin
                        w_pc_d = r_pc + 64'd4;
                    end
                end
            end
            S_HOLD: begin
                w_present   = w_buf_valid;
                w_pres_pc   = w_buf_pc;
                w_pres_inst = w_buf_inst;
                if (!stall) begin
                    w_pc_d    = w_buf_pc + 64'd4;
                    w_state_d = S_REQ;
                    w_buf_inv = 1'b1;
                end
            end
            default: begin
                w_state_d = S_RST;
            end
        endcase

        // Redirects override everything except the post-reset idle cycle;
        // an outstanding request is simply abandoned by the new rom_addr.
        if (r_state != S_RST && (flush || branch_flag)) begin
            w_pc_d     = align_pc(flush ? new_pc : branch_target);
            w_state_d  = S_REQ;
            w_buf_load = 1'b0;
            w_buf_inv  = 1'b1;
            w_present  = 1'b0;
        end
    end

    if_fetch_inst_hold_buf u_hold_buf (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_buf_load),
        .i_invalidate (w_buf_inv),
        .i_pc         (r_pc),
        .i_inst       (rom_data),
        .o_valid      (w_buf_valid),
        .o_pc         (w_buf_pc),
        .o_inst       (w_buf_inst)
    );

    // While rst is high the stage looks exactly like the idle post-reset cycle.
    assign rom_ce          = (rst == RstEnable) ? 1'b0 : w_rom_ce;
    assign rom_addr        = (rst == RstEnable) ? RESET_VECTOR : r_pc;
    assign if_valid        = (rst == RstEnable) ? 1'b0 : w_present;
    assign if_pc           = if_valid ? w_pres_pc : ZeroWord;
    assign if_inst         = if_valid ? w_pres_inst : InstZeroWord;
    assign fetch_stall_req = (rst == RstEnable) ? 1'b0 : w_fsr;

endmodule

`default_nettype wire

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 64'h0, the PC loaded on reset.
REQ-002 clk  in  1  the single clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset; synchronous and active-high (sampled on posedge clk).
REQ-004 stall  in  1  the downstream pipeline is not accepting a fetched instruction this cycle.
REQ-005 flush  in  1  exception or flush redirect request.
REQ-006 new_pc  in  64  flush target, valid when flush=1.
REQ-007 branch_flag  in  1  branch taken, resolved in decode.
REQ-008 branch_target  in  64  branch target, valid when branch_flag=1.
REQ-009 rom_ce  out  1  instruction memory request enable.
REQ-010 rom_addr  out  64  instruction memory byte address.
REQ-011 rom_data  in  32  instruction word, valid when rom_ready=1.
REQ-012 rom_ready  in  1  memory returns data for rom_addr this cycle.
REQ-013 if_pc  out  64  address of the presented instruction; feeds the IF/ID register.
REQ-014 if_inst  out  32  presented instruction word; feeds the IF/ID register.
REQ-015 if_valid  out  1  if_pc and if_inst are valid this cycle.
REQ-016 fetch_stall_req  out  1  fetch is waiting on memory; routed to pipeline control.

Function
REQ-017 FSM states: S_RST (post-reset idle), S_REQ (request outstanding), S_HOLD (instruction buffered during stall).
REQ-018 S_RST: rom_ce=0 and if_valid=0; move to S_REQ on the next edge with pc=RESET_VECTOR. The first request issues one cycle after rst drops.
REQ-019 S_REQ: rom_ce=1 and rom_addr=pc. When rom_ready=1: if_pc=pc, if_inst=rom_data, if_valid=1, all combinationally in the same cycle.
REQ-020 S_REQ with rom_ready=1 and stall=0: on the edge, pc<=pc+4 and the FSM stays in S_REQ. This gives zero-wait throughput of one instruction per cycle.
REQ-021 S_REQ with rom_ready=1 and stall=1: on the edge, capture {pc, rom_data} into the hold buffer, keep pc unchanged, go to S_HOLD.
REQ-022 S_HOLD: rom_ce=0; if_pc, if_inst and if_valid=1 are driven from the hold buffer. When stall=0: on the edge, pc<=held_pc+4 and go to S_REQ.
REQ-023 S_REQ with rom_ready=0: if_valid=0, fetch_stall_req=1, pc is held, rom_addr is stable.
REQ-024 fetch_stall_req=1 only in S_REQ with rom_ready=0; it is 0 in every other case.
REQ-025 Next-pc priority: rst > flush > branch_flag > stall > sequential.
REQ-026 flush=1 in any state except S_RST:
- pc<=new_pc;
- hold buffer invalidated;
- go to S_REQ;
- if_valid forced to 0 in that cycle.
REQ-027 branch_flag=1 (flush=0): pc<=branch_target; hold buffer discarded; go to S_REQ; if_valid forced to 0 in that cycle. This applies even when stall=1.
REQ-028 A redirect while a request is outstanding (rom_ready=0) abandons it. Memory must treat a change of rom_addr as a new request.
REQ-029 Redirect targets are force-aligned: pc<={target[63:2],2'b00}.
REQ-030 PC arithmetic is 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0 with no flag.
REQ-031 When if_valid=0, if_pc and if_inst read 0 (ZeroWord and InstZeroWord).

Reset
REQ-032 rst=1 at an edge has the following effect:
- state<=S_RST;
- pc<=RESET_VECTOR;
- hold buffer cleared.
REQ-033 While in reset and in the following S_RST cycle, outputs are rom_ce=0, rom_addr=RESET_VECTOR, if_pc=0, if_inst=0, if_valid=0, fetch_stall_req=0.
REQ-034 Reset mid-request or in S_HOLD discards all state; no instruction is presented until the reset sequence completes.

Structure
REQ-035 The following belong in the shared defines include:
- RstEnable, ZeroWord, InstZeroWord;
- InstAddrBus (63:0), InstBus (31:0);
- FSM state encodings;
- the default reset vector.
REQ-036 One sub-module is natural: inst_hold_buf (registered pc/inst pair with load and invalidate). The remainder is a flat FSM plus pc register.

Verification
REQ-037 Reset then rom_ready held at 1 -> rom_ce rises one cycle after rst falls; if_pc=0,4,8 on consecutive cycles with if_valid=1.
REQ-038 rom_ready low for 3 cycles at pc=0x10 -> fetch_stall_req=1 and if_valid=0 for 3 cycles; rom_addr stays 0x10; then inst presented with if_pc=0x10.
REQ-039 stall=1 for 2 cycles while ready at pc=0x20 with inst 0xD503201F -> S_HOLD with rom_ce=0 and if_inst=0xD503201F held; after release, next rom_addr=0x24.
REQ-040 branch_flag=1 and flush=1 in the same cycle, new_pc=0x400, branch_target=0x800 -> next rom_addr=0x400; if_valid=0 that cycle.
REQ-041 branch_target=0x1003 during stall in S_HOLD -> buffer dropped; next rom_addr=0x1000.
REQ-042 PC at 64'hFFFF_FFFF_FFFF_FFFC with ready -> next rom_addr=0; rst asserted mid-wait -> state S_RST and rom_ce=0 on the next cycle.
